// File: rtl/note_clk_pkg.sv
// Shared constants for the note clock bank: system clock rate, frequency-to-divisor
// helper and the divisors for the notes the game plays.
package note_clk_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Divisor giving a square wave of hz (one tick per half-period).
  function automatic int unsigned hz_to_div(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned DIV_C4 = hz_to_div(262);
  localparam int unsigned DIV_D4 = hz_to_div(294);
  localparam int unsigned DIV_E4 = hz_to_div(330);
  localparam int unsigned DIV_F4 = hz_to_div(349);
  localparam int unsigned DIV_G4 = hz_to_div(392);
  localparam int unsigned DIV_A4 = hz_to_div(440);
  localparam int unsigned DIV_B4 = hz_to_div(494);
  localparam int unsigned DIV_C5 = hz_to_div(523);
  localparam int unsigned DIV_E5 = hz_to_div(659);
  localparam int unsigned DIV_G5 = hz_to_div(784);
  localparam int unsigned DIV_C6 = hz_to_div(1047);

endpackage

// File: rtl/note_clk_bank_if.sv
// Divisor-write / restart bus and per-channel tick, square and active outputs.
interface note_clk_bank_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 27,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             restart;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  active;

  modport master (
    output wr_en, wr_ch, wr_div, restart,
    input  tick, sq, active
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, restart,
    output tick, sq, active
  );
endinterface

// File: rtl/note_clk_ch.sv
// One divider channel: counter, active/pending divisor, tick strobe and square wave.
module note_clk_ch import note_clk_pkg::*; #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = hz_to_div(1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic             restart_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             active_o
);
  localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;

  assign wrap = (div_cur_q != '0) && (cnt_q == div_cur_q - CNT_W'(1));

  always_comb begin
    cnt_d        = cnt_q;
    div_cur_d    = div_cur_q;
    div_pend_d   = div_pend_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    sq_d         = sq_q;
    if (restart_i) begin
      cnt_d        = '0;
      sq_d         = 1'b0;
      pend_valid_d = 1'b0;
      if (wr_en_i) begin
        div_cur_d = wr_div_i;
      end else if (pend_valid_q) begin
        div_cur_d = div_pend_q;
      end
    end else if (div_cur_q == '0) begin
      // Idle channel: a write takes effect at once, phase starts from zero.
      cnt_d        = '0;
      sq_d         = 1'b0;
      pend_valid_d = 1'b0;
      if (wr_en_i) begin
        div_cur_d = wr_div_i;
      end
    end else begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (pend_valid_q) begin
          div_cur_d    = div_pend_q;
          pend_valid_d = 1'b0;
          if (div_pend_q == '0) begin
            sq_d = 1'b0;
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Running channel defers new divisors to the next wrap so no half-period is cut short.
      if (wr_en_i) begin
        div_pend_d   = wr_div_i;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      div_cur_q    <= ResetDiv;
      div_pend_q   <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_cur_q    <= div_cur_d;
      div_pend_q   <= div_pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
    end
  end

  assign tick_o   = tick_q;
  assign sq_o     = sq_q;
  assign active_o = (div_cur_q != '0);

endmodule

// File: rtl/note_clk_bank.sv
// Bank of N_CH runtime-programmable clock/tone dividers sharing one write port and a
// global phase restart.
module note_clk_bank import note_clk_pkg::*; #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = hz_to_div(1),
  parameter int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic           clk,
  input logic           rst_n,
  note_clk_bank_if.slave bus
);

  if (64'(DEFAULT_DIV) >= (64'd1 << CNT_W)) begin : g_div_check
    $error("note_clk_bank: DEFAULT_DIV does not fit in CNT_W bits");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_wr;
    // Out-of-range channel numbers match no instance, so the write is dropped.
    assign ch_wr = bus.wr_en && (bus.wr_ch == CH_W'(i));

    note_clk_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (ch_wr),
      .wr_div_i  (bus.wr_div),
      .restart_i (bus.restart),
      .tick_o    (bus.tick[i]),
      .sq_o      (bus.sq[i]),
      .active_o  (bus.active[i])
    );
  end

endmodule

// File: tb/tb_note_clk_bank.sv
// Self-checking bench for note_clk_bank: directed steps then random traffic, all
// outputs compared each cycle against a period/phase reference model.
module tb_note_clk_bank;
  localparam int unsigned N_CH        = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned CH_W        = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  note_clk_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  note_clk_bank #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CH_W        (CH_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model: period length, optional pending period, cycles elapsed in the current
  // period, number of square-wave flips since the last phase reset.
  int m_div   [N_CH];
  int m_pend  [N_CH];
  int m_phase [N_CH];
  int m_flips [N_CH];
  bit m_tick  [N_CH];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_div[c]   = DEFAULT_DIV;
      m_pend[c]  = -1;
      m_phase[c] = 0;
      m_flips[c] = 0;
      m_tick[c]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit we_any, input int ch, input int wdiv,
                                     input bit rs);
    for (int c = 0; c < N_CH; c++) begin
      bit we;
      we = we_any && (ch == c);
      if (rs) begin
        if (we) m_div[c] = wdiv;
        else if (m_pend[c] >= 0) m_div[c] = m_pend[c];
        m_pend[c]  = -1;
        m_phase[c] = 0;
        m_flips[c] = 0;
        m_tick[c]  = 1'b0;
      end else if (m_div[c] == 0) begin
        m_tick[c]  = 1'b0;
        m_flips[c] = 0;
        m_phase[c] = 0;
        m_pend[c]  = -1;
        if (we) m_div[c] = wdiv;
      end else begin
        m_phase[c] = m_phase[c] + 1;
        m_tick[c]  = 1'b0;
        if (m_phase[c] == m_div[c]) begin
          m_tick[c]  = 1'b1;
          m_phase[c] = 0;
          m_flips[c] = m_flips[c] + 1;
          if (m_pend[c] >= 0) begin
            m_div[c]  = m_pend[c];
            m_pend[c] = -1;
            if (m_div[c] == 0) m_flips[c] = 0;
          end
        end
        if (we) m_pend[c] = wdiv;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [N_CH-1:0] obs,
                       input logic [N_CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N_CH-1:0] et, es, ea;
    for (int c = 0; c < N_CH; c++) begin
      et[c] = m_tick[c];
      es[c] = (m_flips[c] % 2) != 0;
      ea[c] = (m_div[c] != 0);
    end
    check("model_tick", bus.tick, et);
    check("model_sq", bus.sq, es);
    check("model_active", bus.active, ea);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step(bus.wr_en, int'(bus.wr_ch), int'(bus.wr_div), bus.restart);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_div  = '0;
    bus.restart = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #10;
    check("reset_tick", bus.tick, 4'h0);
    check("reset_sq", bus.sq, 4'h0);
    check("reset_active", bus.active, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // ch1 -> 2 written while cnt=1; it must finish the 4-cycle period first.
    cycle();
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'd1;
    bus.wr_div = 8'd2;
    cycle();
    bus.wr_en = 1'b0;
    cycle();
    check("first_tick_wait", bus.tick, 4'h0);
    cycle();
    check("first_tick", bus.tick, 4'hF);
    check("first_sq", bus.sq, 4'hF);
    run(2);
    check("ch1_fast_tick", bus.tick, 4'b0010);
    check("ch1_fast_sq", bus.sq, 4'b1101);
    run(2);
    check("realign_tick", bus.tick, 4'hF);
    check("realign_sq", bus.sq, 4'b0010);

    // ch2 disable via pending 0, then reload while idle.
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'd2;
    bus.wr_div = 8'd0;
    cycle();
    bus.wr_en = 1'b0;
    run(5);
    check("ch2_disabled_active", bus.active, 4'b1011);
    bus.wr_en  = 1'b1;
    bus.wr_div = 8'd3;
    cycle();
    bus.wr_en = 1'b0;
    run(7);

    // ch3 -> 1: constant tick, sq at clk/2.
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'd3;
    bus.wr_div = 8'd1;
    cycle();
    bus.wr_en = 1'b0;
    run(8);

    // ch0 pending 6, then restart with a same-cycle direct write to ch2.
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'd0;
    bus.wr_div = 8'd6;
    cycle();
    bus.wr_en = 1'b0;
    cycle();
    bus.restart = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd2;
    bus.wr_div  = 8'd5;
    cycle();
    bus.restart = 1'b0;
    bus.wr_en   = 1'b0;
    check("restart_sq", bus.sq, 4'h0);
    check("restart_tick", bus.tick, 4'h0);
    run(14);

    // Out-of-range channel number.
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'd5;
    bus.wr_div = 8'd1;
    cycle();
    bus.wr_en = 1'b0;
    run(6);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tick", bus.tick, 4'h0);
    check("async_rst_sq", bus.sq, 4'h0);
    check("async_rst_active", bus.active, 4'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(6);

    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_ch   = CH_W'($urandom_range(0, 5));
      bus.wr_div  = CNT_W'($urandom_range(0, 7));
      bus.restart = ($urandom_range(0, 39) == 0);
      cycle();
    end
    bus.wr_en   = 1'b0;
    bus.restart = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
